// File: rtl/uart_tx_sched_if.sv
`default_nettype none
// ---- uart_tx_sched_if : producer/transmitter bundle around the UART TX scheduler (rev 1.0) ----
interface uart_tx_sched_if #(
  parameter int N_REQ = 4,
  parameter int CNT_W = 12
);
  logic [N_REQ-1:0]   req;
  logic [8*N_REQ-1:0] req_data;
  logic [N_REQ-1:0]   ack;
  logic [2:0]         grant_id;
  logic               busy;
  logic               frame_done;
  logic               tx_cek;
  logic [CNT_W-1:0]   count;
  logic [7:0]         data;

  // master: the producer side that raises requests and watches the transmitter bus
  modport master (
    output req, req_data,
    input  ack, grant_id, busy, frame_done, tx_cek, count, data
  );

  // slave: the scheduler itself
  modport slave (
    input  req, req_data,
    output ack, grant_id, busy, frame_done, tx_cek, count, data
  );
endinterface
`default_nettype wire

// File: rtl/uart_tx_sched.sv
`default_nettype none
// ---- uart_tx_sched : round-robin arbiter and baud sequencer for a shared 8N1 UART transmitter (rev 1.0) ----
module uart_tx_sched #(
  parameter int N_REQ    = 4,
  parameter int BAUD_DIV = 2604,
  parameter int CNT_W    = 12
) (
  input  logic           clk,
  input  logic           reset,
  uart_tx_sched_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_SEND  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] C_TERM     = CNT_W'(BAUD_DIV);
  localparam logic [CNT_W-1:0] C_PRE_TERM = CNT_W'(BAUD_DIV - 1);
  localparam logic [3:0]       C_LAST_BIT = 4'd9;
  localparam logic [2:0]       C_LAST_REQ = 3'(N_REQ - 1);
  localparam logic [3:0]       C_NREQ     = 4'(N_REQ);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [3:0]       bit_idx_q, bit_idx_d;
  logic [2:0]       rr_ptr_q, rr_ptr_d;
  logic             tx_cek_q, tx_cek_d;
  logic [N_REQ-1:0] ack_q, ack_d;
  logic             busy_q, busy_d;
  logic             frame_done_q, frame_done_d;
  logic [7:0]       data_q, data_d;
  logic [2:0]       grant_id_q, grant_id_d;

  logic [7:0]       w_req_pad;
  logic [63:0]      w_data_pad;
  logic [3:0]       w_idx;
  logic [2:0]       w_pick;
  logic             w_found;
  logic [7:0]       w_onehot;

  assign w_req_pad  = 8'(bus.req);
  assign w_data_pad = 64'(bus.req_data);

  // first set request at or after rr_ptr, wrapping modulo N_REQ
  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    w_idx   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      w_idx = {1'b0, rr_ptr_q} + 4'(i);
      if (w_idx >= C_NREQ) begin
        w_idx = w_idx - C_NREQ;
      end
      if (!w_found && w_req_pad[w_idx[2:0]]) begin
        w_found = 1'b1;
        w_pick  = w_idx[2:0];
      end
    end
  end

  assign w_onehot = 8'd1 << w_pick;

  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    bit_idx_d    = bit_idx_q;
    rr_ptr_d     = rr_ptr_q;
    tx_cek_d     = 1'b0;
    ack_d        = '0;
    busy_d       = busy_q;
    frame_done_d = 1'b0;
    data_d       = data_q;
    grant_id_d   = grant_id_q;

    case (state_q)
      S_IDLE: begin
        count_d   = '0;
        bit_idx_d = '0;
        if (w_found) begin
          // strobe and ack are registered, so they appear during the START cycle
          state_d    = S_START;
          data_d     = w_data_pad[{w_pick, 3'b000} +: 8];
          grant_id_d = w_pick;
          rr_ptr_d   = (w_pick == C_LAST_REQ) ? 3'd0 : w_pick + 3'd1;
          busy_d     = 1'b1;
          tx_cek_d   = 1'b1;
          ack_d      = w_onehot[N_REQ-1:0];
        end
      end

      S_START: begin
        state_d   = S_SEND;
        count_d   = '0;
        bit_idx_d = '0;
      end

      S_SEND: begin
        if (count_q == C_TERM) begin
          count_d = '0;
          if (bit_idx_q == C_LAST_BIT) begin
            state_d   = S_IDLE;
            bit_idx_d = '0;
            busy_d    = 1'b0;
          end else begin
            bit_idx_d = bit_idx_q + 4'd1;
          end
        end else begin
          count_d = count_q + 1'b1;
        end
        // registered pulse lands in the cycle where the last bit reaches terminal count
        if (bit_idx_q == C_LAST_BIT && count_q == C_PRE_TERM) begin
          frame_done_d = 1'b1;
        end
      end

      default: begin
        state_d = S_IDLE;
        count_d = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      count_q      <= '0;
      bit_idx_q    <= '0;
      rr_ptr_q     <= '0;
      tx_cek_q     <= 1'b0;
      ack_q        <= '0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      data_q       <= 8'h00;
      grant_id_q   <= '0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      bit_idx_q    <= bit_idx_d;
      rr_ptr_q     <= rr_ptr_d;
      tx_cek_q     <= tx_cek_d;
      ack_q        <= ack_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      data_q       <= data_d;
      grant_id_q   <= grant_id_d;
    end
  end

  assign bus.ack        = ack_q;
  assign bus.grant_id   = grant_id_q;
  assign bus.busy       = busy_q;
  assign bus.frame_done = frame_done_q;
  assign bus.tx_cek     = tx_cek_q;
  assign bus.count      = count_q;
  assign bus.data       = data_q;

endmodule
`default_nettype wire
